aoi21_pipe_bank: RTL
====================

# aoi21_pipe_bank

Parametrised, pipelined bank of WIDTH AOI21/OAI21 lanes, the sequential successor to the single-bit AOI21X1 cell. Each lane is selectable between AOI21 and OAI21, and each lane has a saturating output-toggle counter. The block sits in the SoC flow's characterisation and activity path: it drives registered complex-gate results into downstream logic and exposes per-lane switching activity for power estimation.

## Interface
Parameters:
- WIDTH, 8, number of lanes (1..32)
- STAGES, 2, pipeline depth in registers (1..4)
- CNTW, 16, toggle-counter width per lane (2..32)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- EN  in  1  pipeline advance enable; 0 stalls all stages
- MODE  in  1  0: Y = ~((A&B)|C); 1: Y = ~((A|B)&C); sampled with data at stage 1
- VIN  in  1  input data valid
- A, B, C  in  WIDTH each  lane operands
- Y  out  WIDTH  last pipeline stage result
- VOUT  out  1  valid flag of the last stage
- CLR  in  1  synchronous clear of all toggle counters and the reference register
- SEL  in  max(1,$clog2(WIDTH))  lane select for counter readout
- CNT  out  CNTW  counter of lane SEL (combinational mux); 0 if SEL >= WIDTH
- SAT  out  1  selected counter equals 2^CNTW-1; 0 if SEL >= WIDTH

## Operation
- Stage 1 input: the gate function chosen by MODE, applied per lane to A/B/C. The result and VIN enter stage 1.
- EN=1 on a rising edge: every stage shifts forward by one, carrying data and valid together.
- EN=0: all stages, valid bits, the reference register and the counters hold. CLR still acts.
- Invalid data (VIN=0) moves through the pipeline normally. Y always shows the last-stage data, whatever VOUT is.
- Reference register REF (WIDTH bits) holds the last valid output word.
- Count event: an advance that loads the last stage with valid=1.
  - For each lane where the new data bit differs from REF, that lane's counter increments by 1.
  - Counters saturate at 2^CNTW-1 and never wrap.
  - REF is then loaded with the new word.
  - An advance that loads valid=0 leaves the counters and REF unchanged.
- CLR=1: all counters and REF are set to 0 on that edge. CLR has priority over a simultaneous count event, so that event is discarded.
- MODE can change on any cycle. Each word keeps the mode it was sampled with, so mixed modes inside the pipeline are legal.

## Timing
- Reset values (asynchronous, applied immediately):
  - all stage data and valid bits, REF and all counters = 0
  - therefore Y=0, VOUT=0, CNT=0, SAT=0
- Latency: a word presented with EN=1 appears on Y/VOUT after exactly STAGES advancing edges. Each EN=0 cycle adds one cycle.
- Throughput: one word per cycle while EN=1.
- CNT/SAT follow SEL combinationally, in the same cycle. Counter updates are visible in the cycle after the counting edge.
- RST asserted mid-stream: all in-flight words are discarded and counters are lost. After RST deasserts, the first advancing edge loads stage 1. Y stays 0 until the refill completes.
- A first valid word after reset or CLR is compared against REF=0, so any 1 bits in it count as toggles.

## Test plan
- Reset: assert RST asynchronously mid-cycle with the pipeline full. Required: Y=0, VOUT=0 and CNT=0 immediately, without waiting for CLK.
- Truth table (WIDTH=8, STAGES=2, EN=1, VIN=1): lane 0 walks through all 8 A/B/C combinations with MODE=0, then MODE=1.
  - Each result appears 2 cycles later.
  - MODE=0: A=1,B=1,C=0 gives Y[0]=0; A=0,B=1,C=0 gives Y[0]=1.
  - MODE=1: A=0,B=0,C=1 gives Y[0]=1; A=1,B=0,C=1 gives Y[0]=0.
- Stall: send words W0, W1, W2 and drop EN for 3 cycles after W1 enters. Required:
  - W0 appears at cycle 2; W1 appears at cycle 6 instead of 3.
  - Y and counters are frozen during the stall; no word is lost or duplicated.
- Toggle and saturation (CNTW=4): send alternating valid words 0xFF and 0x00, SEL=3. Required:
  - CNT increments once per word, reaching 15 after 15 words with SAT=1.
  - It stays at 15 on further words.
  - Interleaving VIN=0 words changes nothing.
- CLR with count event: assert CLR on the same edge as a valid toggling word. Required:
  - CNT=0 afterwards and REF=0.
  - The next valid word 0x01 gives lane 0 count 1 and lane 1 count 0.
- SEL out of range: WIDTH=6, SEL=7. Required: CNT=0 and SAT=0 even while lane counters are nonzero.

Source files
------------

// File: rtl/aoi21_pipe_bank.sv
// ============================================================================
// Module   : aoi21_pipe_bank
// Brief    : WIDTH lanes of selectable AOI21/OAI21 gates feeding a STAGES-deep
//            pipeline, with a saturating output-toggle counter on every lane
//            and a combinational per-lane counter readout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aoi21_pipe_bank #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNTW   = 16,
  localparam int SELW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             MODE,
  input  logic             VIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Y,
  output logic             VOUT,
  input  logic             CLR,
  input  logic [SELW-1:0]  SEL,
  output logic [CNTW-1:0]  CNT,
  output logic             SAT
);

  localparam logic [CNTW-1:0] c_cnt_max = '1;

  logic [WIDTH-1:0] w_gate;
  logic [WIDTH-1:0] r_data [STAGES];
  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0] w_last_d;
  logic             w_last_v;
  logic             w_event;
  logic [CNTW-1:0]  r_cnt [WIDTH];
  logic [WIDTH-1:0] r_ref;
  logic [CNTW-1:0]  w_cnt;
  logic             w_hit;

  // MODE is applied here, so each word carries the function it was sampled with
  assign w_gate = MODE ? ~((A | B) & C) : ~((A & B) | C);

  // Data/valid shift register; a low EN freezes every stage together
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < STAGES; s++) begin
        r_data[s] <= '0;
      end
      r_vld <= '0;
    end else if (EN) begin
      r_data[0] <= w_gate;
      r_vld[0]  <= VIN;
      for (int s = 1; s < STAGES; s++) begin
        r_data[s] <= r_data[s-1];
        r_vld[s]  <= r_vld[s-1];
      end
    end
  end

  // Word about to be loaded into the last stage on an advancing edge
  generate
    if (STAGES == 1) begin : g_single_stage
      assign w_last_d = w_gate;
      assign w_last_v = VIN;
    end else begin : g_multi_stage
      assign w_last_d = r_data[STAGES-2];
      assign w_last_v = r_vld[STAGES-2];
    end
  endgenerate

  assign w_event = EN & w_last_v;

  // Toggle counters and reference word; CLR wins over a coincident count event
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_ref <= '0;
    end else if (CLR) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_ref <= '0;
    end else if (w_event) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((w_last_d[i] != r_ref[i]) && (r_cnt[i] != c_cnt_max)) begin
          r_cnt[i] <= r_cnt[i] + CNTW'(1);
        end
      end
      r_ref <= w_last_d;
    end
  end

  // Readout mux; an out-of-range SEL matches no lane and reads as zero
  always_comb begin
    w_cnt = '0;
    w_hit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (SEL == SELW'(i)) begin
        w_cnt = r_cnt[i];
        w_hit = 1'b1;
      end
    end
  end

  assign CNT  = w_cnt;
  assign SAT  = w_hit && (w_cnt == c_cnt_max);
  assign Y    = r_data[STAGES-1];
  assign VOUT = r_vld[STAGES-1];

endmodule

`default_nettype wire
